init_cfg_tx: RTL and testbench
==============================

# init_cfg_tx

Host-side transmitter for the ANC chip's serial initialization port. It holds the chip in reset, releases it, then streams a 22-bit configuration word one bit per clock on `init_out`, LSB first and cycle-aligned. The chip's init shift register therefore captures the word exactly as its packed fields define it. It sits in the FPGA bench/control fabric, on the same `clk` as the chip, and drives the chip's `rst_n` and `init_in` pins.

## Interface
Parameters:
- `INIT_LEN`, 22: number of configuration bits shifted after reset release.
- `RST_HOLD`, 16: cycles `chip_rst_n` is held low per load. Must be ≥1.

Ports (reset is `rst_n`, asynchronous, active-low; clock is `clk`):
- `clk`, in, 1: system clock, shared with the chip.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: single-cycle request to (re)program the chip. Sampled only in IDLE or DONE.
- `in_clk_period`, in, 8: i2s input sck period. Word bits [21:14].
- `out_clk_period`, in, 8: i2s output bclk period. Word bits [13:6].
- `bypass_mode_sel`, in, 1: FPGA weight-bypass enable. Word bit [5].
- `prog_delay_sel`, in, 5: programmable delay select. Word bits [4:0].
- `chip_rst_n`, out, 1: registered reset to the chip.
- `init_out`, out, 1: registered serial config bit to the chip's `init_in`.
- `busy`, out, 1: high in HOLD and SHIFT.
- `done`, out, 1: high in DONE. The chip's `init_done` is asserted.

## Operation
- FSM states are IDLE, HOLD, SHIFT and DONE. The reset state is IDLE.
- Reset values: `chip_rst_n`=0, `init_out`=0, `busy`=0, `done`=0, shift register=0, counter=0.
- IDLE: `chip_rst_n`=0. When `start`=1:
  - latch {`in_clk_period`,`out_clk_period`,`bypass_mode_sel`,`prog_delay_sel`} into `shreg`;
  - load the counter with RST_HOLD-1;
  - go to HOLD.
- HOLD: `chip_rst_n`=0 and the counter decrements. On the edge where counter==0:
  - set `chip_rst_n`<=1 and `init_out`<=`shreg[0]`;
  - shift `shreg` right by one;
  - set the counter to INIT_LEN-1 and go to SHIFT.
- SHIFT: on each edge, `init_out`<=`shreg[0]`, `shreg` shifts right, and the counter decrements. When the counter is 0 at the edge:
  - go to DONE;
  - `init_out`<=0.
- DONE: `chip_rst_n` stays 1 and `done`=1. When `start`=1, relatch the inputs, set `chip_rst_n`<=0, and go to HOLD. This is a full re-initialization.
- `start` during HOLD or SHIFT is ignored. Config inputs are only sampled on the accepted `start` edge; later changes have no effect.
- Async `rst_n` mid-load: immediate return to IDLE with `chip_rst_n`=0. This aborts the chip's init, which is safe because the chip restarts its init on the next release.
- Bit order: word bit k appears on `init_out` during the k-th cycle after release. This matches the chip's right-shift register, where the newest bit enters at the MSB.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let T0 be the edge where HOLD exits (`chip_rst_n` rises and `init_out`=bit0 after T0). Then:
  - the chip samples bit k at edge T(k+1), for k=0..21;
  - `init_out` shows bit k+1 after T(k+1);
  - the chip sets `init_done` at T22, and this block enters DONE at the same edge T22.
- Latency from `start` accepted (edge S) to `chip_rst_n` high is RST_HOLD cycles. Total latency from S to `done` is RST_HOLD+INIT_LEN cycles.
- `busy` is high from S+1 through T22; `done` rises after T22. The two are never high together.

## Structure
- Package `anc_init_pkg` holds:
  - INIT_LEN;
  - field LSB/width constants: IN_PER_LSB=14, OUT_PER_LSB=6, BYPASS_BIT=5, DELAY_LSB=0;
  - the FSM state enum.
- The chip-side init deserializer must use the same package constants so the field packing is shared.
- The block is a single module with no sub-module. The FSM, one down-counter of width $clog2(max(RST_HOLD,INIT_LEN)) and the shift register are all inline.

## Test plan
- Reset values: assert `rst_n`=0 mid-sim -> all outputs 0 immediately. After release, state stays IDLE with `chip_rst_n`=0.
- Basic load with in=0x20, out=0x40, bypass=1, delay=0x0A, RST_HOLD=16:
  - `chip_rst_n` rises exactly 16 cycles after `start`;
  - `init_out` sequence equals word 0x081_02A, LSB first;
  - a reference model of the chip's shift register (right shift, 22 cycles) holds 0x08102A at T22;
  - `done`=1.
- Reprogram: in DONE, pulse `start` with delay=0x1F -> `chip_rst_n` falls on the next edge, a new 16+22 cycle sequence follows, and the model captures the new word.
- Ignored start: pulse `start` at SHIFT bit 7 with different config -> the stream is unchanged and `done` is reached on schedule.
- Abort: assert `rst_n` during SHIFT bit 10 -> `chip_rst_n`=0 and `busy`=0 immediately. A subsequent `start` completes normally.
- Input stability: change config inputs every cycle after `start` -> the captured word equals the values present at the `start` edge.

Source files
------------

// File: rtl/anc_init_pkg.sv
// Shared constants and types for the ANC chip serial initialization word.
// The chip-side deserializer imports this package too, so both ends agree on field packing.
package anc_init_pkg;

    localparam int unsigned INIT_LEN    = 22;

    localparam int unsigned IN_PER_LSB  = 14;
    localparam int unsigned IN_PER_W    = 8;
    localparam int unsigned OUT_PER_LSB = 6;
    localparam int unsigned OUT_PER_W   = 8;
    localparam int unsigned BYPASS_BIT  = 5;
    localparam int unsigned DELAY_LSB   = 0;
    localparam int unsigned DELAY_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } init_state_e;

    // Field view of the configuration word, MSB first.
    typedef struct packed {
        logic [IN_PER_W-1:0]  in_clk_period;
        logic [OUT_PER_W-1:0] out_clk_period;
        logic                 bypass_mode_sel;
        logic [DELAY_W-1:0]   prog_delay_sel;
    } init_cfg_t;

    typedef logic [INIT_LEN-1:0] init_word_t;

    // Place each field at its LSB constant.
    function automatic init_word_t pack_init_word(
        input logic [IN_PER_W-1:0]  in_per,
        input logic [OUT_PER_W-1:0] out_per,
        input logic                 bypass,
        input logic [DELAY_W-1:0]   delay
    );
        init_word_t w;
        w = '0;
        w[IN_PER_LSB  +: IN_PER_W]  = in_per;
        w[OUT_PER_LSB +: OUT_PER_W] = out_per;
        w[BYPASS_BIT]               = bypass;
        w[DELAY_LSB   +: DELAY_W]   = delay;
        return w;
    endfunction

endpackage

// File: rtl/init_cfg_tx.sv
// Host-side transmitter for the ANC chip init port: holds the chip in reset,
// releases it, then streams the configuration word LSB first on init_out.
module init_cfg_tx
    import anc_init_pkg::*;
#(
    parameter int unsigned INIT_LEN = anc_init_pkg::INIT_LEN,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [IN_PER_W-1:0]  in_clk_period,
    input  logic [OUT_PER_W-1:0] out_clk_period,
    input  logic                 bypass_mode_sel,
    input  logic [DELAY_W-1:0]   prog_delay_sel,
    output logic                 chip_rst_n,
    output logic                 init_out,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_MAX = (RST_HOLD > INIT_LEN) ? RST_HOLD : INIT_LEN;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    init_state_e         state;
    logic [CNT_W-1:0]    cnt;
    logic [INIT_LEN-1:0] shreg;
    init_word_t          cfg_word;

    assign cfg_word = pack_init_word(in_clk_period, out_clk_period,
                                     bypass_mode_sel, prog_delay_sel);

    // Sequencer: reset hold, then one config bit per clock, then park in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            chip_rst_n <= 1'b0;
            init_out   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    chip_rst_n <= 1'b0;
                    init_out   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        shreg <= INIT_LEN'(cfg_word);
                        cnt   <= CNT_W'(RST_HOLD - 1);
                        busy  <= 1'b1;
                        state <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    chip_rst_n <= 1'b0;
                    if (cnt == '0) begin
                        chip_rst_n <= 1'b1;
                        init_out   <= shreg[0];
                        shreg      <= shreg >> 1;
                        cnt        <= CNT_W'(INIT_LEN - 1);
                        state      <= ST_SHIFT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_SHIFT: begin
                    init_out <= shreg[0];
                    shreg    <= shreg >> 1;
                    if (cnt == '0) begin
                        init_out <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    // A new start is a full re-initialization of the chip.
                    if (start) begin
                        shreg      <= INIT_LEN'(cfg_word);
                        cnt        <= CNT_W'(RST_HOLD - 1);
                        chip_rst_n <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= ST_HOLD;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_init_cfg_tx.sv
// Self-checking bench for init_cfg_tx: table vectors, corner sequences and random loads
// against a timeline model plus a model of the chip's right-shift capture register.
module tb_init_cfg_tx;

    localparam int RH = 16;
    localparam int IL = 22;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_clk_period = '0;
    logic [7:0] out_clk_period = '0;
    logic       bypass_mode_sel = 1'b0;
    logic [4:0] prog_delay_sel = '0;
    logic       chip_rst_n, init_out, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [21:0] chip_sr = '0;
    int          chip_cnt = 0;

    init_cfg_tx #(.INIT_LEN(IL), .RST_HOLD(RH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .in_clk_period   (in_clk_period),
        .out_clk_period  (out_clk_period),
        .bypass_mode_sel (bypass_mode_sel),
        .prog_delay_sel  (prog_delay_sel),
        .chip_rst_n      (chip_rst_n),
        .init_out        (init_out),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Chip model: held in reset while chip_rst_n is low, then captures IL bits by right shift.
    always @(posedge clk) begin
        if (!chip_rst_n) begin
            chip_sr  <= '0;
            chip_cnt <= 0;
        end else if (chip_cnt < IL) begin
            chip_sr  <= {init_out, chip_sr[21:1]};
            chip_cnt <= chip_cnt + 1;
        end
    end

    function automatic logic [21:0] ref_word(input logic [7:0] i, input logic [7:0] o,
                                             input logic b, input logic [4:0] d);
        int unsigned v;
        v = 32'(i) * 16384 + 32'(o) * 64 + 32'(b) * 32 + 32'(d);
        return 22'(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/chip_rst_n"}, 32'(chip_rst_n), 0);
        chk({tag, "/init_out"},   32'(init_out),   0);
        chk({tag, "/busy"},       32'(busy),       0);
        chk({tag, "/done"},       32'(done),       0);
    endtask

    // mode 0 plain, 1 scramble config every cycle, 2 stray start at bit 7, 3 abort at bit 10.
    task automatic load(input logic [7:0] i, input logic [7:0] o, input logic b,
                        input logic [4:0] d, input logic [21:0] w, input int mode,
                        input string tag);
        logic exp_bit;
        in_clk_period   = i;
        out_clk_period  = o;
        bypass_mode_sel = b;
        prog_delay_sel  = d;
        start           = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n <= RH + IL; n++) begin
            exp_bit = (n >= RH && n < RH + IL) ? w[n - RH] : 1'b0;
            chk({tag, "/busy"},       32'(busy),       32'(n < RH + IL));
            chk({tag, "/done"},       32'(done),       32'(n == RH + IL));
            chk({tag, "/chip_rst_n"}, 32'(chip_rst_n), 32'(n >= RH));
            chk({tag, "/init_out"},   32'(init_out),   32'(exp_bit));
            if (n == RH + IL) begin
                chk({tag, "/chip_word"}, 32'(chip_sr), 32'(w));
                chk({tag, "/chip_cnt"},  32'(chip_cnt), 32'(IL));
            end
            if (mode == 1 || (mode == 2 && n == RH + 7)) begin
                in_clk_period   = 8'($urandom);
                out_clk_period  = 8'($urandom);
                bypass_mode_sel = 1'($urandom);
                prog_delay_sel  = 5'($urandom);
            end
            start = (mode == 2 && n == RH + 7);
            if (mode == 3 && n == RH + 10) begin
                rst_n = 1'b0;
                #1;
                chk_idle({tag, "/abort"});
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk_idle({tag, "/post_abort"});
                return;
            end
            if (n < RH + IL) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  i;
        logic [7:0]  o;
        logic        b;
        logic [4:0]  d;
        logic [21:0] w;
        int          mode;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{8'h20, 8'h40, 1'b1, 5'h0A, 22'h08102A, 0};
        tbl[1] = '{8'h20, 8'h40, 1'b1, 5'h1F, 22'h08103F, 0};
        tbl[2] = '{8'hA5, 8'h3C, 1'b0, 5'h11, 22'h294F11, 2};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 5'h1F, 22'h3FFFFF, 3};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 5'h00, 22'h000000, 0};
        tbl[5] = '{8'h01, 8'h80, 1'b1, 5'h00, 22'h006020, 1};

        #2;
        chk_idle("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_idle("idle_after_reset");
        end

        for (int v = 0; v < 6; v++)
            load(tbl[v].i, tbl[v].o, tbl[v].b, tbl[v].d, tbl[v].w, tbl[v].mode,
                 $sformatf("vec%0d", v));

        for (int r = 0; r < 8; r++) begin
            logic [7:0] ri, ro;
            logic       rb;
            logic [4:0] rd;
            ri = 8'($urandom);
            ro = 8'($urandom);
            rb = 1'($urandom);
            rd = 5'($urandom);
            load(ri, ro, rb, rd, ref_word(ri, ro, rb, rd), int'($urandom_range(0, 2)),
                 $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
